// File: rtl/div_sequencer.sv
// div_sequencer: iterative radix-2 restoring divider for the execute stage.
// Serves div.w / mod.w / div.wu / mod.wu. Operands are latched on an
// in_valid/in_ready handshake, one quotient bit is produced per cycle, the
// sign fix-up is applied on entry to DONE, and the result is held until the
// consumer takes it with out_ready. A flush aborts any operation.
//
// Configuration macro: DIV_EARLY_OUT_EN
//   defined   : |x| < |y| (y != 0) finishes at accept with q=0, r=x.
//   undefined : every nonzero divisor takes the full DATA_W+1 cycle latency.
module div_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              div_signed,
  input  logic              div_quot,
  input  logic [DATA_W-1:0] div_x,
  input  logic [DATA_W-1:0] div_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] div_result,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              signed_q;
  logic              quot_q;
  logic              x_sign_q;
  logic              y_sign_q;
  logic [DATA_W-1:0] dvd_q;   // dividend bits shifting out, quotient bits shifting in
  logic [DATA_W-1:0] dsr_q;   // |y|
  logic [DATA_W-1:0] rem_q;   // partial remainder

  // Accept-cycle operand conditioning
  logic              x_neg, y_neg, y_zero, early_out;
  logic [DATA_W-1:0] x_abs, y_abs;

  // One restoring step
  logic [DATA_W:0]   shifted, diff;
  logic              q_bit, last_iter;
  logic [DATA_W-1:0] rem_next, quo_next, q_fix, r_fix;

  // Operand magnitudes and shortcut detection for the accept cycle
  always_comb begin
    x_neg  = div_signed & div_x[DATA_W-1];
    y_neg  = div_signed & div_y[DATA_W-1];
    // Two's-complement negation of the most negative value yields the same bit
    // pattern, which read as unsigned is exactly its magnitude.
    x_abs  = x_neg ? (~div_x + 1'b1) : div_x;
    y_abs  = y_neg ? (~div_y + 1'b1) : div_y;
    y_zero = (div_y == '0);
`ifdef DIV_EARLY_OUT_EN
    early_out = !y_zero && (x_abs < y_abs);
`else
    early_out = 1'b0;
`endif
  end

  // Shift-in, trial subtract and sign fix-up of the step's outcome
  always_comb begin
    shifted   = {rem_q, dvd_q[DATA_W-1]};
    diff      = shifted - {1'b0, dsr_q};
    q_bit     = ~diff[DATA_W];
    rem_next  = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_next  = {dvd_q[DATA_W-2:0], q_bit};
    q_fix     = (signed_q & (x_sign_q ^ y_sign_q)) ? (~quo_next + 1'b1) : quo_next;
    r_fix     = (signed_q & x_sign_q) ? (~rem_next + 1'b1) : rem_next;
    last_iter = (cnt_q == CNT_W'(DATA_W - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers sample
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition including an accept
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for state_d.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = (y_zero || early_out) ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // Datapath: latch at accept, iterate in CALC, write the result on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      quot_q     <= 1'b0;
      x_sign_q   <= 1'b0;
      y_sign_q   <= 1'b0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      div_result <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            signed_q <= div_signed;
            quot_q   <= div_quot;
            x_sign_q <= x_neg;
            y_sign_q <= y_neg;
            dvd_q    <= x_abs;
            dsr_q    <= y_abs;
            rem_q    <= '0;
            cnt_q    <= '0;
            if (y_zero)         div_result <= div_quot ? '1 : div_x;
            else if (early_out) div_result <= div_quot ? '0 : div_x;
          end
        end
        CALC: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          if (last_iter) begin
            cnt_q      <= '0;
            div_result <= quot_q ? q_fix : r_fix;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and randomised checks of div_sequencer.
// Expected results and latencies are queued when a request is driven and
// popped when the divider presents its result.
module tb_div_sequencer;

  localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic         div_signed, div_quot;
  logic [W-1:0] div_x, div_y;
  logic         out_valid, out_ready;
  logic [W-1:0] div_result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  div_sequencer #(.DATA_W(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_signed (div_signed),
    .div_quot   (div_quot),
    .div_x      (div_x),
    .div_y      (div_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_result (div_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result using native 64-bit arithmetic (truncating division)
  function automatic logic [W-1:0] model(input logic sgn, input logic quot,
                                         input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    if (y == '0) return quot ? '1 : x;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return quot ? q[W-1:0] : r[W-1:0];
  endfunction

  function automatic int model_lat(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ax, ay;
    if (y == '0) return 1;
    ax = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    ay = sgn ? longint'($signed(y)) : longint'({32'b0, y});
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    if (ax < ay) return EARLY_LAT;
    return 33;
  endfunction

  // Issue one request, wait (bounded) for the result, optionally stall the consumer
  task automatic do_op(input logic sgn, input logic quot, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp_r,
                       input int exp_lat, input int stall);
    int           cyc;
    int           el;
    logic [W-1:0] e, held;
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    div_signed = sgn;
    div_quot   = quot;
    div_x      = x;
    div_y      = y;
    out_ready  = (stall == 0);
    exp_q.push_back(exp_r);
    lat_q.push_back(exp_lat);
    @(negedge clk);                      // accept edge has passed: cycle 1
    in_valid   = 1'b0;
    div_x      = $urandom;
    div_y      = $urandom;
    div_signed = 1'($urandom);
    div_quot   = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check("out_valid_rise", 32'(out_valid), 32'd1);
    check("latency", 32'(cyc), 32'(el));
    check("result", div_result, e);
    held = div_result;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result", div_result, held);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (i == stall - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    check("consumed_out_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    logic         seen;
    logic         rs, rq;
    logic [W-1:0] rx, ry;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    div_signed = 1'b0; div_quot = 1'b0; div_x = '0; div_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", div_result, 32'd0);

    // Unsigned basics
    do_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 33, 0);
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd2, 33, 0);

    // Signed: -7 / 2
    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);

    // Signed overflow and zero divisor
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    do_op(1'b0, 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op(1'b0, 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0);
    do_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 1, 0);

    // Flush in CALC cycle 10
    @(negedge clk);
    in_valid = 1'b1; div_signed = 1'b0; div_quot = 1'b1; div_x = 32'd1000; div_y = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    do_op(1'b0, 1'b1, 32'd1000, 32'd3, 32'd333, 33, 0);

    // Flush and request in the same cycle: nothing accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; div_x = 32'd5; div_y = 32'd1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_wins_busy", 32'(busy), 32'd0);
    check("flush_wins_in_ready", 32'(in_ready), 32'd1);

    // Back-pressure: consumer stalls for 5 cycles in DONE
    do_op(1'b0, 1'b1, 32'd50, 32'd5, 32'd10, 33, 5);

    // Early-out candidates
    do_op(1'b0, 1'b1, 32'd3, 32'd9, 32'd0, EARLY_LAT, 0);
    do_op(1'b0, 1'b0, 32'd3, 32'd9, 32'd3, EARLY_LAT, 0);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD, EARLY_LAT, 0);
    do_op(1'b1, 1'b1, 32'd0, 32'hFFFF_FFF0, 32'd0, EARLY_LAT, 0);

    // Reset during CALC clears the result and returns to idle
    @(negedge clk);
    in_valid = 1'b1; div_signed = 1'b0; div_quot = 1'b1; div_x = 32'd77; div_y = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_calc_result", div_result, 32'd0);
    check("reset_calc_busy", 32'(busy), 32'd0);
    check("reset_calc_out_valid", 32'(out_valid), 32'd0);

    // Randomised operands against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom);
      rq = 1'($urandom);
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 31);
      do_op(rs, rq, rx, ry, model(rs, rq, rx, ry), model_lat(rs, rx, ry), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
